// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind the UART receiver.
// Tracks level, full/empty/almost-full status and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DBIT      = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   din,
    input  logic              rd,
    input  logic              ovf_clr,
    output logic [DBIT-1:0]   dout,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W + 1)'(AF_THRESH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_ok;
    logic              we;
    logic              drop;

    assign empty       = (level == '0);
    assign full        = (level == FULL_LVL);
    assign almost_full = (level >= AF_LVL);
    assign dout        = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign rd_ok = rd & ~empty;
    assign we    = rx_done_tick & (~full | rd_ok);
    assign drop  = rx_done_tick & ~we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (we) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({we, rd_ok})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue model.
// Directed steps pin model and DUT to literal values from the test plan.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] din;
    logic       rd;
    logic       ovf_clr;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_ovf;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_THRESH(12)) dut (
        .clk(clk),
        .reset(reset),
        .rx_done_tick(rx_done_tick),
        .din(din),
        .rd(rd),
        .ovf_clr(ovf_clr),
        .dout(dout),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .level(level),
        .overflow(overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored bytes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            automatic bit was_full = (q.size() == 16);
            automatic bit rdok = rd && (q.size() > 0);
            automatic bit wok = rx_done_tick && (!was_full || rdok);
            if (rdok) void'(q.pop_front());
            if (wok) q.push_back(din);
            if (rx_done_tick && !wok) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("level", level, q.size());
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == 16);
            chk("almost_full", almost_full, q.size() >= 12);
            chk("overflow", overflow, m_ovf);
            if (q.size() > 0) chk("dout", dout, q[0]);
        end
    end

    task automatic step(input bit w, input logic [7:0] d,
                        input bit r, input bit c);
        rx_done_tick = w;
        din          = d;
        rd           = r;
        ovf_clr      = c;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd           = 1'b0;
        ovf_clr      = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        din          = '0;
        rd           = 1'b0;
        ovf_clr      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_dout", dout, 0);
        reset = 1'b0;
        @(negedge clk);

        step(1, 8'hA5, 0, 0);
        chk("a5_empty", empty, 0);
        chk("a5_level", level, 1);
        chk("a5_dout", dout, 8'hA5);
        step(0, 0, 1, 0);
        chk("a5_pop_empty", empty, 1);
        chk("a5_pop_level", level, 0);

        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0);
            chk("fill_af", almost_full, (i + 1) >= 12);
        end
        chk("fill_full", full, 1);
        chk("fill_level", level, 16);

        step(1, 8'h55, 0, 0);
        chk("drop_level", level, 16);
        chk("drop_ovf", overflow, 1);
        step(0, 0, 0, 1);
        chk("clr_ovf", overflow, 0);

        step(1, 8'h77, 1, 0);
        chk("rw_full_level", level, 16);
        chk("rw_full_ovf", overflow, 0);
        chk("rw_full_dout", dout, 8'h01);
        for (int i = 1; i < 16; i++) begin
            chk("drain_dout", dout, i);
            step(0, 0, 1, 0);
        end
        chk("drain_last", dout, 8'h77);
        step(0, 0, 1, 0);
        chk("drain_empty", empty, 1);

        step(0, 0, 1, 0);
        chk("rd_empty_level", level, 0);
        step(1, 8'h3C, 1, 0);
        chk("rw_empty_level", level, 1);
        chk("rw_empty_dout", dout, 8'h3C);
        step(0, 0, 1, 0);

        for (int n = 0; n < 3000; n++) begin
            automatic int ph = (n / 250) % 2;
            automatic bit w = ($urandom_range(99) < (ph ? 30 : 70));
            automatic bit r = ($urandom_range(99) < (ph ? 70 : 30));
            automatic bit c = ($urandom_range(99) < 5);
            step(w, 8'($urandom), r, c);
        end

        while (!empty) step(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(1, 8'h55, 0, 0);
        step(1, 8'h66, 0, 0);
        step(1, 8'h77, 0, 0);
        step(1, 8'h88, 0, 0);
        step(1, 8'h99, 0, 0);
        step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 0, 0);
        chk("pre_rst_ovf", overflow, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ovf", overflow, 0);
        chk("arst_dout", dout, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        step(1, 8'h81, 0, 0);
        chk("post_rst_dout", dout, 8'h81);
        chk("post_rst_level", level, 1);
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. Each rx_done_tick pulse from the receiver, with its data byte, is written into the FIFO. Host logic drains bytes through a first-word-fall-through read port. The block provides level and full/empty/almost-full status plus a sticky overflow flag, so bytes arriving in bursts at line rate are not lost while the consumer is busy.

Parameters:
DBIT, 8, data width in bits; matches receiver word width
ADDR_W, 4, address width; depth = 2**ADDR_W entries (16)
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; legal range 1..2**ADDR_W

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_done_tick  input  1  one-clock write strobe from the receiver
din  input  DBIT  received byte; sampled on the clk edge where rx_done_tick=1
rd  input  1  pop request; head entry is removed on the clk edge where rd=1 and empty=0
dout  output  DBIT  head-of-FIFO data (FWFT); valid whenever empty=0
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2**ADDR_W entries
almost_full  output  1  level >= AF_THRESH
level  output  ADDR_W+1  current number of stored entries, 0..2**ADDR_W
overflow  output  1  sticky; set when a write is dropped because the FIFO is full
ovf_clr  input  1  synchronous clear for overflow

Behaviour:
- Clock is clk. Reset is asynchronous, active-high; reset is clk.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_full=0, overflow=0. The storage array resets to 0, so dout=0.
- Reset asserted mid-operation discards all contents and forces the reset values immediately, independent of clk.
- Storage: register array of 2**ADDR_W x DBIT, with wr_ptr/rd_ptr each ADDR_W bits.
  - Pointers wrap naturally from 2**ADDR_W-1 to 0.
  - full/empty derive from the level counter, not from pointer compare.
- Write accept: we = rx_done_tick & (~full | rd_ok).
  - On accept: mem[wr_ptr] <= din and wr_ptr increments.
- Read accept: rd_ok = rd & ~empty.
  - On accept: rd_ptr increments.
  - rd while empty is ignored, with no side effects.
- dout = mem[rd_ptr], read combinationally: zero-latency FWFT.
  - A byte written at edge N is visible on dout, with empty=0, after edge N.
  - After a pop at edge N, the next entry is on dout after edge N.
- Level update per edge:
  - +1 on write only
  - -1 on read only
  - unchanged on simultaneous accepted write and read, or on neither
- Simultaneous events:
  - Full, with rd=1 and rx_done_tick=1: both accepted, level stays 2**ADDR_W, no overflow.
  - Empty, with rd=1 and rx_done_tick=1: read ignored, write accepted, level becomes 1.
  - Full, with rx_done_tick=1 and rd=0: byte dropped, memory and pointers unchanged, overflow <= 1.
- overflow:
  - Set on any dropped write.
  - Cleared by ovf_clr=1 at the next edge.
  - If a drop and ovf_clr occur in the same cycle, set wins and overflow stays 1.
- Status outputs empty, full, almost_full and level are registered, or derived combinationally from the registered level; all update in the same cycle as level.
- No internal state machine beyond the pointers and counter. The block accepts a write on every cycle (no throttling), so it is safe for any s_tick rate.

Test Plan:
- Reset, then write 0xA5 (one rx_done_tick) -> after that edge: empty=0, level=1, dout=0xA5. Pulse rd -> empty=1, level=0.
- Write 0x00..0x0F (16 bytes) -> full=1, level=16, almost_full=1 from the 12th write onward. Read 16 times -> dout sequence 0x00..0x0F in order, then empty=1.
- While full, write 0x55 with rd=0 -> level stays 16, overflow=1, and later reads never return 0x55. Pulse ovf_clr -> overflow=0 on the next edge.
- While full, write 0x77 and rd together -> level=16, overflow=0, dout advances by one entry, and 0x77 emerges last after draining.
- While empty, pulse rd alone -> no change (level=0, pointers unchanged). rd and write of 0x3C together -> level=1, dout=0x3C.
- After 10 writes, assert reset asynchronously between edges -> level=0, empty=1, overflow=0, dout=0 immediately. After reset release, the first write of 0x81 appears at dout=0x81.
